// File: rtl/fader_pkg.sv
// Shared definitions for the PDM brightness fader: FSM state encoding
// and the power-on values of the step and rate configuration registers.
package fader_pkg;

  // IDLE holds the level and the prescaler. RAMP walks the level toward the target.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  // Reset values of the step and rate registers.
  // A step of 1 is also the substitute for a requested step of 0.
  localparam int unsigned DEFAULT_STEP = 1;
  localparam int unsigned DEFAULT_RATE = 0;

endpackage

// File: rtl/pdm_fader_if.sv
// Host/PDM-facing bundle of the fader.
// The master drives the target and config strobes. The slave (the fader)
// drives the level strobe and the status flags.
interface pdm_fader_if #(
  parameter int NBITS     = 16,
  parameter int RATE_BITS = 16
);

  logic [NBITS-1:0]     target_in;
  logic                 target_write;
  logic [NBITS-1:0]     step_in;
  logic [RATE_BITS-1:0] rate_in;
  logic                 cfg_write;
  logic [NBITS-1:0]     level_out;
  logic                 level_write;
  logic                 busy;
  logic                 done;

  modport master (
    output target_in, target_write, step_in, rate_in, cfg_write,
    input  level_out, level_write, busy, done
  );

  modport slave (
    input  target_in, target_write, step_in, rate_in, cfg_write,
    output level_out, level_write, busy, done
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler for the fader. While enabled it counts 0..i_rate and fires
// o_tick in the cycle the count equals i_rate. i_clr forces the count to 0.
module tick_gen #(
  parameter int RATE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [RATE_BITS-1:0] i_rate,
  output logic                 o_tick
);

  logic [RATE_BITS-1:0] r_cnt;
  logic                 w_wrap;

  assign w_wrap = (r_cnt == i_rate);
  assign o_tick = i_en && !i_clr && w_wrap;

  // Count modulo rate+1 while enabled. Clear has priority so the first
  // period after a restart is always a full rate+1 cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + RATE_BITS'(1);
    end
  end

endmodule

// File: rtl/pdm_fader.sv
// Brightness ramp generator feeding the nixie PDM stage.
// The output level moves toward the latched target in fixed steps, one
// step per prescaler tick. Each new level comes with a one-cycle
// level_write strobe, and the final step lands exactly on the target.
module pdm_fader
  import fader_pkg::*;
#(
  parameter int NBITS     = 16,
  parameter int RATE_BITS = 16
) (
  input logic        clk,
  input logic        rst,
  pdm_fader_if.slave bus
);

  state_t               r_state;
  logic [NBITS-1:0]     r_target;
  logic [NBITS-1:0]     r_step;
  logic [RATE_BITS-1:0] r_rate;
  logic [NBITS-1:0]     r_level;
  logic                 r_level_write;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_tick;
  logic [NBITS-1:0]     w_step_fix;
  logic [NBITS:0]       w_diff;
  logic [NBITS:0]       w_abs;
  logic                 w_close;
  logic [NBITS-1:0]     w_level_next;

  // The prescaler idles at zero, so entering RAMP always starts a fresh period.
  tick_gen #(
    .RATE_BITS(RATE_BITS)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == ST_IDLE),
    .i_en  (r_state == ST_RAMP),
    .i_rate(r_rate),
    .o_tick(w_tick)
  );

  // A requested step of zero would stall the ramp forever, so treat it as 1.
  assign w_step_fix = (bus.step_in == '0) ? NBITS'(DEFAULT_STEP) : bus.step_in;

  // Take the one-bit-wider difference as two's complement. Bit NBITS is the
  // sign, and the magnitude always fits because both operands are unsigned NBITS.
  assign w_diff  = {1'b0, r_target} - {1'b0, r_level};
  assign w_abs   = w_diff[NBITS] ? (~w_diff + 1'b1) : w_diff;
  assign w_close = (w_abs <= {1'b0, r_step});

  // This path is taken only when |diff| > step, so the add or subtract
  // cannot cross the target and cannot wrap.
  assign w_level_next = w_diff[NBITS] ? (r_level - r_step) : (r_level + r_step);

  // Main FSM. Configuration and target latching, level stepping, and
  // all registered outputs are handled here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_target      <= '0;
      r_step        <= NBITS'(DEFAULT_STEP);
      r_rate        <= RATE_BITS'(DEFAULT_RATE);
      r_level       <= '0;
      r_level_write <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_level_write <= 1'b0;
      r_done        <= 1'b0;

      if (bus.cfg_write) begin
        r_step <= w_step_fix;
        r_rate <= bus.rate_in;
      end

      // A tick in this same cycle still reads the old r_target.
      if (bus.target_write) begin
        r_target <= bus.target_in;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.target_write) begin
            if (bus.target_in != r_level) begin
              r_state <= ST_RAMP;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RAMP: begin
          if (w_tick) begin
            r_level_write <= 1'b1;
            if (w_close) begin
              r_level <= r_target;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_level <= w_level_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_out   = r_level;
  assign bus.level_write = r_level_write;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_pdm_fader.sv
// Self-checking bench for pdm_fader. Expected strobe timing and levels come
// from closed-form ramp arithmetic: strobe k of n lands rate+1 cycles after
// strobe k-1, at level + k*step, and the last strobe is exactly the target.
module tb_pdm_fader;

  localparam int NB = 16;
  localparam int RB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pdm_fader_if #(.NBITS(NB), .RATE_BITS(RB)) bus ();

  pdm_fader #(.NBITS(NB), .RATE_BITS(RB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: the level the fader should hold when idle, plus the
  // effective step and rate.
  int m_level = 0;
  int m_step  = 1;
  int m_rate  = 0;

  typedef struct {
    int step_in;
    int rate_in;
    int target;
    int exp_n;
    int exp_first;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cfg(input int step_in, input int rate_in);
    @(negedge clk);
    bus.step_in   = NB'(step_in);
    bus.rate_in   = RB'(rate_in);
    bus.cfg_write = 1'b1;
    @(negedge clk);
    bus.cfg_write = 1'b0;
    m_step = (step_in == 0) ? 1 : step_in;
    m_rate = rate_in;
  endtask

  // Issue one target_write, optionally with a same-cycle cfg_write, then walk
  // the whole expected ramp plus a quiet window. Every cycle is checked.
  task automatic ramp(input int tgt, input bit with_cfg, input int step_in, input int rate_in,
                      output int seen, output int first_lv);
    int d, mag, n, sgn, c, k, lv, last_c;
    @(negedge clk);
    bus.target_in    = NB'(tgt);
    bus.target_write = 1'b1;
    if (with_cfg) begin
      bus.step_in   = NB'(step_in);
      bus.rate_in   = RB'(rate_in);
      bus.cfg_write = 1'b1;
      m_step = (step_in == 0) ? 1 : step_in;
      m_rate = rate_in;
    end
    @(negedge clk);
    bus.target_write = 1'b0;
    bus.cfg_write    = 1'b0;
    d   = tgt - m_level;
    mag = (d < 0) ? -d : d;
    sgn = (d < 0) ? -1 : 1;
    n   = (mag + m_step - 1) / m_step;
    seen = 0;
    first_lv = -1;
    k = 1;
    if (n == 0) begin
      chk("eq_done", bus.done, 1);
      chk("eq_busy", bus.busy, 0);
      chk("eq_write", bus.level_write, 0);
    end
    last_c = 1 + n * (m_rate + 1) + m_rate + 2;
    for (c = 1; c <= last_c; c++) begin
      if (bus.level_write === 1'b1) begin
        seen++;
        if (first_lv < 0) first_lv = int'(bus.level_out);
      end
      if (k <= n && c == 1 + k * (m_rate + 1)) begin
        lv = (k == n) ? tgt : m_level + sgn * k * m_step;
        chk("strobe", bus.level_write, 1);
        chk("level", bus.level_out, lv);
        chk("done_at_strobe", bus.done, (k == n));
        chk("busy_at_strobe", bus.busy, (k != n));
        k++;
      end else if (!(c == 1 && n == 0)) begin
        chk("no_strobe", bus.level_write, 0);
        chk("no_done", bus.done, 0);
        chk("busy_between", bus.busy, (k <= n));
        chk("level_hold", bus.level_out, (k == 1) ? m_level :
            ((k - 1 == n) ? tgt : m_level + sgn * (k - 1) * m_step));
      end
      @(negedge clk);
    end
    $display("ramp from=%04h tgt=%04h step=%0d rate=%0d strobes=%0d expected=%0d",
             m_level, tgt, m_step, m_rate, seen, n);
    m_level = tgt;
  endtask

  initial begin
    int seen, first_lv, sel, st, rt, tg, eff;
    bus.target_in    = '0;
    bus.target_write = 1'b0;
    bus.step_in      = '0;
    bus.rate_in      = '0;
    bus.cfg_write    = 1'b0;

    vecs[0]  = '{4,      0, 'h0010,   4, 'h0004};
    vecs[1]  = '{'hFFFF, 0, 'h0000,   1, 'h0000};
    vecs[2]  = '{'h1000, 9, 'hFFFF,  16, 'h1000};
    vecs[3]  = '{'h0100, 0, 'h0100, 255, 'hFEFF};
    vecs[4]  = '{'h0040, 1, 'h0003,   4, 'h00C0};
    vecs[5]  = '{0,      2, 'h0006,   3, 'h0004};
    vecs[6]  = '{7,      0, 'h0006,   0, -1};
    vecs[7]  = '{'h3000, 0, 'hFFFF,   6, 'h3006};
    vecs[8]  = '{'h3000, 0, 'h0000,   6, 'hCFFF};
    vecs[9]  = '{1,      0, 'h0002,   2, 'h0001};
    vecs[10] = '{'h0010, 0, 'h0022,   2, 'h0012};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_level", bus.level_out, 0);
    chk("rst_write", bus.level_write, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b1;

    // Table-driven ramps. Each one starts from where the previous one ended.
    for (int i = 0; i < 11; i++) begin
      cfg(vecs[i].step_in, vecs[i].rate_in);
      ramp(vecs[i].target, 1'b0, 0, 0, seen, first_lv);
      chk("tbl_count", seen, vecs[i].exp_n);
      chk("tbl_first", first_lv, vecs[i].exp_first);
    end

    // Retarget mid-ramp: rising toward 0x100, redirect to 0x20 while at 0x40.
    ramp(0, 1'b1, 'hFFFF, 0, seen, first_lv);
    cfg('h20, 3);
    @(negedge clk);
    bus.target_in = 16'h0100;
    bus.target_write = 1'b1;
    @(negedge clk);
    bus.target_write = 1'b0;
    repeat (8) @(negedge clk);
    chk("rt_write40", bus.level_write, 1);
    chk("rt_level40", bus.level_out, 'h40);
    bus.target_in = 16'h0020;
    bus.target_write = 1'b1;
    @(negedge clk);
    bus.target_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("rt_quiet", bus.level_write, 0);
    @(negedge clk);
    chk("rt_write20", bus.level_write, 1);
    chk("rt_level20", bus.level_out, 'h20);
    chk("rt_done", bus.done, 1);
    chk("rt_busy", bus.busy, 0);
    $display("retarget 0100->0020 at level 0040 finished at %04h", bus.level_out);
    m_level = 'h20;

    // Reset mid-ramp aborts immediately and restores the step and rate defaults.
    cfg(5, 2);
    @(negedge clk);
    bus.target_in = 16'h8000;
    bus.target_write = 1'b1;
    @(negedge clk);
    bus.target_write = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_level", bus.level_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_write", bus.level_write, 0);
    chk("mid_rst_done", bus.done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", bus.level_write, 0);
    end
    $display("reset mid-ramp: level=%04h busy=%0b", bus.level_out, bus.busy);
    m_level = 0;
    m_step  = 1;
    m_rate  = 0;
    ramp(3, 1'b0, 0, 0, seen, first_lv);
    chk("dflt_count", seen, 3);
    chk("dflt_first", first_lv, 1);

    // Randomized ramps, with config applied either ahead of or with the target.
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      st = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 'h20) : $urandom_range('h100, 'hFFFF);
      rt = $urandom_range(0, 3);
      eff = (st == 0) ? 1 : st;
      if ($urandom_range(0, 7) == 0) begin
        tg = m_level;
      end else if (eff < 'h100) begin
        tg = m_level + $urandom_range(0, 'h80) - 'h40;
        if (tg < 0) tg = 0;
        if (tg > 'hFFFF) tg = 'hFFFF;
      end else begin
        tg = $urandom_range(0, 'hFFFF);
      end
      if ($urandom_range(0, 1) == 1) begin
        ramp(tg, 1'b1, st, rt, seen, first_lv);
      end else begin
        cfg(st, rt);
        ramp(tg, 1'b0, 0, 0, seen, first_lv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_fader.md
# pdm_fader

Brightness ramp generator directly upstream of the nixie PDM stage. It accepts a target brightness from the host register interface and moves its output level toward that target in fixed steps at a programmable rate. Each new level is presented with a one-cycle write strobe that drives the PDM's `pwm_write`/`PWM_in` pair, giving smooth fades instead of brightness jumps.

## Interface
- `NBITS`, default 16: level width; must match PDM `NBITS`.
- `RATE_BITS`, default 16: prescaler width.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `target_in`  in  NBITS  requested brightness.
- `target_write`  in  1  one-cycle strobe that latches `target_in`.
- `step_in`  in  NBITS  level increment per tick; a value of 0 is treated as 1.
- `rate_in`  in  RATE_BITS  ticks occur every `rate_in`+1 clocks.
- `cfg_write`  in  1  strobe that latches `step_in` and `rate_in`.
- `level_out`  out  NBITS  current level, connected to PDM `PWM_in`.
- `level_write`  out  1  one-cycle strobe, connected to PDM `pwm_write`.
- `busy`  out  1  high while ramping.
- `done`  out  1  one-cycle pulse when `level_out` reaches the target.

## Operation
- Registers:
  - `target`, `step`, `rate`, `level`.
  - Prescaler `cnt` (RATE_BITS wide).
  - State: IDLE or RAMP.
- Reset (`rst`=0) values:
  - `target`=0, `level`=0, `step`=1, `rate`=0, `cnt`=0, state IDLE.
  - Outputs: `level_out`=0, `level_write`=0, `busy`=0, `done`=0.
  - Reset mid-ramp aborts immediately and issues no final `level_write`.
- `cfg_write`:
  - Latches `step` = (`step_in`==0 ? 1 : `step_in`) and `rate`.
  - Legal in any state; takes effect at the next tick evaluation.
- `target_write`:
  - Latches `target` in every state.
  - IDLE with `target_in`≠`level`: go to RAMP and clear `cnt` to 0.
  - IDLE with `target_in`==`level`: stay in IDLE, pulse `done` next cycle, no `level_write`.
  - RAMP: retarget only. `cnt` is not cleared, and direction is recomputed at the next tick.
- Simultaneous `cfg_write` and `target_write`: both are latched in the same cycle.
- RAMP prescaler:
  - Each cycle: if `cnt`==`rate`, then `cnt`←0 and tick; else `cnt`←`cnt`+1.
- Tick arithmetic:
  - diff = `target` − `level`, computed at NBITS+1 bits, signed.
  - If |diff| ≤ `step`: `level`←`target`, assert `done`, go to IDLE.
  - Else: `level` ← `level` ± `step` toward `target`.
  - No overshoot and no wrap; 0 and 2^NBITS−1 are reached exactly.
  - Every tick asserts `level_write` with the new `level`.
- A `target_write` in the same cycle as a tick uses the old `target` for that tick; the new `target` applies from the next tick.
- IDLE: `cnt` holds at 0, no strobes.

## Timing
- `target_write` in cycle T (from IDLE): `busy`=1 from T+1. With `cnt` cleared, the first tick is at T+1+`rate`, and the new `level_out` plus `level_write` are visible at T+2+`rate`.
- Subsequent `level_write` pulses are spaced exactly `rate`+1 cycles apart.
- `level_out` and `level_write` are registered together. `level_out` is stable until the next strobe, so the PDM may latch it on the strobe.
- Final step: `done`=1 and `level_write`=1 in the same cycle; `busy`=0 from that cycle.
- Total ramp length: ceil(|target−level| / step) strobes.

## Structure
- Shared package/header `fader_pkg`:
  - State encoding constants `ST_IDLE` and `ST_RAMP`.
  - Default `step` (1) and default `rate` (0).
- One sub-module, `tick_gen`: a RATE_BITS prescaler with clear and enable inputs and a tick output.
- The main FSM and arithmetic stay in `pdm_fader`.

## Test plan
- Reset, then `target_write` 0x0010 with `step`=4, `rate`=0 → `level_write` on 4 consecutive cycles with levels 4, 8, 12, 16. `done` coincides with level 16, and `busy` spans 4 cycles.
- `rate`=9, `step`=0x1000, target 0xFFFF from 0 → strobes every 10 cycles with levels 0x1000 through 0xF000, then 0xFFFF. No wrap, 16 strobes total.
- Ramp down from 0x0100 to 0x0003 with `step`=0x40 → levels 0xC0, 0x80, 0x40, then 0x03, with no underflow.
- Retarget mid-ramp: rising toward 0x100, write target 0x20 while level is 0x40 → the next tick goes down to 0x20 (step ≥ 0x20), then `done`.
- `target_write` equal to the current level → `done` pulse at T+1, no `level_write`, `busy` stays 0. `step_in`=0 via `cfg_write` → ramp advances by 1 per tick.
- Assert `rst`=0 mid-ramp → the next cycle shows `level_out`=0, `busy`=0, no strobes, and `step`/`rate` back at their defaults.
